// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: req/ack fetch FSM, small circular instruction
// buffer toward decode, and jump/branch redirect with squash of stale fetches.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        opcode,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [PTR_W:0]    DEPTH_C    = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    CNT_ONE    = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(3'd4);
    localparam logic [ADDR_W-1:0] RESET_PC_A = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [ADDR_W-1:0] req_addr_r;
    logic [ADDR_W-1:0] req_addr_nxt_s;
    logic [ADDR_W-1:0] jmp_pc_s;
    logic              jmp_lsb_unused_s;
    logic              push_s;
    logic              pop_s;

    logic [31:0]       buf_data_r [DEPTH];
    logic [ADDR_W-1:0] buf_pc_r   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [PTR_W:0]    count_nxt_s;

    // Redirect targets are forced to word alignment; the low bits are dropped.
    assign jmp_pc_s         = {jmp_target[ADDR_W-1:2], 2'b00};
    assign jmp_lsb_unused_s = ^jmp_target[1:0];

    // A redirect flushes the buffer, so a concurrent pop is meaningless.
    assign pop_s = instr_valid && instr_ready && !jmp_valid;

    // Fetch FSM next state, next PC and request address.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        req_addr_nxt_s = req_addr_r;
        push_s         = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (jmp_valid) begin
                    pc_nxt_s = jmp_pc_s;
                end else if (count_r < DEPTH_C) begin
                    req_addr_nxt_s = pc_r;
                    state_nxt_s    = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (jmp_valid) begin
                    pc_nxt_s    = jmp_pc_s;
                    state_nxt_s = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    push_s      = 1'b1;
                    pc_nxt_s    = pc_r + PC_STEP;
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_DROP: begin
                // The request cannot be retracted; wait for its ack and discard it.
                if (jmp_valid) begin
                    pc_nxt_s = jmp_pc_s;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (imem_ack) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DROP;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Buffer occupancy update.
    always_comb begin
        count_nxt_s = count_r;
        if (jmp_valid) begin
            count_nxt_s = '0;
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Fetch FSM, PC and request-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            pc_r       <= RESET_PC_A;
            req_addr_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            req_addr_r <= req_addr_nxt_s;
        end
    end

    // Instruction buffer storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data_r[i] <= 32'd0;
                buf_pc_r[i]   <= '0;
            end
        end else begin
            count_r <= count_nxt_s;
            if (jmp_valid) begin
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    buf_data_r[wr_ptr_r] <= imem_rdata;
                    buf_pc_r[wr_ptr_r]   <= req_addr_r;
                    wr_ptr_r             <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
        end
    end

    assign imem_req    = (state_r == S_REQ) || (state_r == S_DROP);
    assign imem_addr   = req_addr_r;
    assign instr_valid = (count_r != '0);
    assign instr       = instr_valid ? buf_data_r[rd_ptr_r] : 32'd0;
    assign instr_pc    = instr_valid ? buf_pc_r[rd_ptr_r] : '0;
    assign opcode      = instr[31:26];

endmodule
